// File: rtl/instr_encoder_pkg.sv
// Shared constants and the encode helper for the MIPS instruction encoder.
package instr_encoder_pkg;

  localparam logic [2:0] KIND_RTYPE = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_ADDI  = 3'd4;

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;
  localparam logic [2:0] FUNC_AND = 3'd2;
  localparam logic [2:0] FUNC_OR  = 3'd3;
  localparam logic [2:0] FUNC_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [2:0] kind, input logic [2:0] func,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [15:0] imm);
    enc_t       e;
    logic [5:0] fn;
    e.legal = 1'b1;
    e.word  = '0;
    fn      = FN_ADD;
    case (kind)
      KIND_RTYPE: begin
        case (func)
          FUNC_ADD: fn = FN_ADD;
          FUNC_SUB: fn = FN_SUB;
          FUNC_AND: fn = FN_AND;
          FUNC_OR:  fn = FN_OR;
          FUNC_SLT: fn = FN_SLT;
          default:  e.legal = 1'b0;
        endcase
        e.word = {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
      end
      KIND_LW:   e.word = {OP_LW, rs, rt, imm};
      KIND_SW:   e.word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  e.word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI: e.word = {OP_ADDI, rs, rt, imm};
      default:   e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO with an optional second write in the same cycle (wdata2 lands
// in the slot after wdata). Occupancy counter drives full/empty/free.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push2,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH-1:0]         wdata2,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push2;
  logic             do_pop;
  logic [AW:0]      push_n;

  assign do_push2 = push && push2;
  assign do_pop   = pop && !empty;
  assign push_n   = (AW+1)'(push) + (AW+1)'(do_push2);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
    if (do_push2) mem[wr_ptr + AW'(1)] <= wdata2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + push_n - (AW+1)'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign free  = (AW+1)'(DEPTH) - cnt;

endmodule

// File: rtl/instr_encoder.sv
// Encodes operation requests into MIPS words and streams them out through a FIFO.
// Optional macro INSTR_ENCODER_NOP_INSERT_EN appends a delay-slot NOP after each BEQ.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_kind,
  input  logic [2:0]       req_func,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [15:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_word,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_err
);
  localparam int AW = $clog2(DEPTH);

  enc_t        enc;
  logic        need_two;
  logic        accept;
  logic        push;
  logic        push2;
  logic        pop;
  logic [31:0] head;
  logic [31:0] last_word;
  logic [AW:0] free;
  logic        full;
  logic        empty;

  assign enc = encode(req_kind, req_func, req_rs, req_rt, req_rd, req_imm);

`ifdef INSTR_ENCODER_NOP_INSERT_EN
  assign need_two = (req_kind == KIND_BEQ);
`else
  assign need_two = 1'b0;
`endif

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign req_ready = !full && (!need_two || (free >= (AW+1)'(2)));
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc.legal;
  assign push2     = push && need_two;
  assign pop       = instr_valid && instr_ready;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .push2  (push2),
    .wdata  (enc.word),
    .wdata2 (NOP_WORD),
    .pop    (pop),
    .rdata  (head),
    .free   (free),
    .full   (full),
    .empty  (empty)
  );

  // When empty the output keeps showing the last word that was handed off.
  assign instr_valid = !empty;
  assign instr_word  = empty ? last_word : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_word   <= '0;
      instr_count <= '0;
      illegal_err <= 1'b0;
    end else begin
      if (pop) begin
        last_word   <= head;
        instr_count <= instr_count + CNT_W'(1);
      end
      if (accept && !enc.legal) illegal_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue scoreboard and reference encoder.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [2:0]  req_func = '0;
  logic [4:0]  req_rs = '0;
  logic [4:0]  req_rt = '0;
  logic [4:0]  req_rd = '0;
  logic [15:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_word;
  logic [15:0] instr_count;
  logic        illegal_err;

  logic [31:0] exp_q[$];
  logic [15:0] exp_count = '0;
  logic        exp_illegal = 1'b0;
  int          ncmp = 0;
  int          nfail = 0;
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_func(req_func), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_word(instr_word),
    .instr_count(instr_count), .illegal_err(illegal_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the opcode/funct tables.
  function automatic logic [32:0] ref_encode(input int kind, input int func, input int rs,
                                             input int rt, input int rd, input int imm);
    int op;
    int fn;
    logic [31:0] w;
    fn = 0;
    case (kind)
      0: op = 0;
      1: op = 35;
      2: op = 43;
      3: op = 4;
      4: op = 8;
      default: return {1'b0, 32'h0};
    endcase
    if (kind == 0) begin
      case (func)
        0: fn = 32;
        1: fn = 34;
        2: fn = 36;
        3: fn = 37;
        4: fn = 42;
        default: return {1'b0, 32'h0};
      endcase
      w = 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn);
    end else begin
      w = 32'(op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
    end
    return {1'b1, w};
  endfunction

  // driver: call just after a rising edge; returns just after the accepting edge
  task automatic send(input int kind, input int func, input int rs, input int rt,
                      input int rd, input int imm);
    logic [32:0] r;
    int waited;
    waited = 0;
    req_valid = 1'b1;
    req_kind = 3'(kind); req_func = 3'(func);
    req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd); req_imm = 16'(imm);
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 500) begin
        nfail++;
        $display("FAIL send_timeout: req_ready stuck low, kind %0d", kind);
        @(posedge clk); #1 req_valid = 1'b0;
        return;
      end
    end
    r = ref_encode(kind, func, rs, rt, rd, imm);
    if (r[32]) begin
      exp_q.push_back(r[31:0]);
`ifdef INSTR_ENCODER_NOP_INSERT_EN
      if (kind == 3) exp_q.push_back(32'h0);
`endif
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!r[32]) exp_illegal = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || instr_valid) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    ncmp++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: %0d words left, needed 0", exp_q.size());
    end
  endtask

  // instr_ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) instr_ready = 1'($urandom_range(0, 1));
  end

  // monitor / scoreboard
  initial begin
    bit          holding;
    logic [31:0] held;
    logic [31:0] exp_w;
    holding = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("instr_count", 32'(instr_count), 32'(exp_count));
        check("illegal_err", 32'(illegal_err), 32'(exp_illegal));
        if (holding && !instr_valid) check("valid_dropped", 32'(instr_valid), 32'd1);
        if (instr_valid) begin
          if (holding) check("hold_stable", instr_word, held);
          if (instr_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_word", instr_word, 32'hxxxx_xxxx);
            end else begin
              exp_w = exp_q.pop_front();
              check("instr_word", instr_word, exp_w);
            end
            exp_count = exp_count + 16'd1;
            holding = 1'b0;
          end else begin
            holding = 1'b1;
            held = instr_word;
          end
        end else begin
          holding = 1'b0;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  // main sequence
  initial begin
    int kind;
    int func;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_word", instr_word, 32'h0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_illegal", 32'(illegal_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;
    instr_ready = 1'b1;

    send(0, 0, 1, 2, 3, 0);
    @(negedge clk);
    check("first_latency_valid", 32'(instr_valid), 32'd1);
    check("first_word", instr_word, 32'h0022_1820);
    @(posedge clk); #1;
    @(negedge clk);
    check("first_count", 32'(instr_count), 32'd1);
    @(posedge clk); #1;

    send(1, 0, 29, 8, 0, 4);
    send(2, 0, 2, 4, 0, 8);
    send(4, 0, 0, 5, 0, 7);
    wait_drain(50);

    // fill with downstream stalled
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(0, $urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535));
    req_valid = 1'b1;
    req_kind = 3'd0; req_func = 3'd1;
    repeat (3) begin
      @(negedge clk);
      check("full_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    send(0, 1, 7, 8, 9, 0);
    wait_drain(50);

`ifdef INSTR_ENCODER_NOP_INSERT_EN
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 0, i, i + 1, 0, i * 4);
    req_valid = 1'b1;
    req_kind = 3'd3;
    repeat (2) begin
      @(negedge clk);
      check("beq_held_off", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    send(3, 0, 1, 2, 0, 16'hFFFF);
    wait_drain(50);
`endif

    // illegal kind, then a BEQ
    send(7, 0, 3, 3, 3, 3);
    @(negedge clk);
    check("illegal_set", 32'(illegal_err), 32'd1);
    check("illegal_no_output", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    send(3, 0, 1, 2, 0, 16'hFFFF);
    wait_drain(50);

    // random traffic
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) kind = $urandom_range(5, 7);
      else kind = $urandom_range(0, 4);
      func = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      send(kind, func, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain(2000);
    rdy_rand = 1'b0;
    @(posedge clk); #1;

    // reset with queued words and a request offered in the reset cycle
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2, 0, i, 2 * i, 0, i + 100);
    mon_en = 1'b0;
    rst = 1'b1;
    req_valid = 1'b1;
    req_kind = 3'd1; req_func = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    exp_count = '0;
    exp_illegal = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_count", 32'(instr_count), 32'd0);
    check("mid_rst_illegal", 32'(illegal_err), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_word", instr_word, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    instr_ready = 1'b1;
    send(4, 0, 6, 7, 0, 16'h1234);
    wait_drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the main control decoder: takes operation requests (kind, register fields, immediate) and encodes them into 32-bit MIPS instruction words.
- Buffers the words in a small FIFO and streams them out over valid/ready to the instruction-memory loader or testbench program feeder.
- Supported ops: R-type (add/sub/and/or/slt), lw, sw, beq, addi.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  encoder can accept a request this cycle.
- req_kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI; 5-7 illegal.
- req_func  input  3  R-type only: 0=add, 1=sub, 2=and, 3=or, 4=slt; 5-7 illegal.
- req_rs  input  5  source register.
- req_rt  input  5  target register.
- req_rd  input  5  destination register (R-type only).
- req_imm  input  16  immediate / offset (I-type only).
- instr_valid  output  1  instr_word holds a valid instruction.
- instr_ready  input  1  downstream accepts the word.
- instr_word  output  32  encoded instruction.
- instr_count  output  CNT_W  number of completed output handshakes.
- illegal_err  output  1  sticky flag: an illegal request was seen.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FIFO empty, instr_valid=0, instr_word=0, instr_count=0, illegal_err=0, req_ready=1 on the cycle after reset.
- Reset mid-operation: all queued entries are discarded. A handshake in the reset cycle has no effect.
- Request handshake: accept when req_valid && req_ready. req_ready = !full, registered count only; there is no same-cycle pass-through when the FIFO is full.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}. funct: add=100000, sub=100010, and=100100, or=100101, slt=101010.
  - I-type: {op, rs, rt, imm}. op: LW=100011, SW=101011, BEQ=000100, ADDI=001000.
  - rd is ignored for I-type. imm is ignored for R-type.
- Latency: a word accepted in cycle N appears on instr_word with instr_valid=1 in cycle N+1 at the earliest. Output order is strictly FIFO.
- Output handshake: a word is popped when instr_valid && instr_ready. instr_word and instr_valid stay stable while instr_valid && !instr_ready.
- Empty FIFO: instr_valid=0 and instr_word holds its last value.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations succeed.
- Pointers: wrap modulo DEPTH. Full/empty is derived from an occupancy counter of width log2(DEPTH)+1.
- Illegal request (kind 5-7, or RTYPE with func 5-7):
  - The request is consumed (handshake completes) but not enqueued.
  - illegal_err is set the next cycle and stays set until rst.
- instr_count: increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: INSTR_ENCODER_NOP_INSERT_EN.
- Defined:
  - Every accepted BEQ is followed in the FIFO by a delay-slot NOP (32'h00000000).
  - A BEQ request is accepted only when at least 2 entries are free; other kinds need 1.
  - The BEQ and its NOP are enqueued in the same cycle.
  - The NOP counts toward instr_count when popped.
- Undefined: no NOP insertion; the single-slot rule applies to all kinds.

Decomposition:
- Package instr_encoder_pkg holds:
  - the kind codes (KIND_RTYPE..KIND_ADDI) and func codes;
  - 6-bit opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - 6-bit funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - NOP_WORD.
- Sub-module instr_fifo: synchronous FIFO parameterised by DEPTH and WIDTH=32. It exposes push, pop, free-slot count, full, and empty, and supports a dual push for NOP insertion.
- The top level holds the encode logic, illegal detection, and the counter.

Test Plan:
- After reset, RTYPE add rs=1 rt=2 rd=3 with instr_ready=1 -> instr_word=0x00221820 one cycle after accept; instr_count=1 after pop.
- Back-to-back requests LW rs=29 rt=8 imm=4, SW rs=2 rt=4 imm=8, ADDI rs=0 rt=5 imm=7 -> outputs in order 0x8FA80004, 0xAC440008, 0x20050007.
- instr_ready=0 with DEPTH+1 requests -> req_ready falls after 4 accepts and instr_word stays stable. Then raise instr_ready -> all 4 words drain in order and instr_count=4.
- req_kind=7 -> handshake completes, nothing is output, illegal_err=1 and stays 1 until rst. A following BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
- rst asserted with 3 queued words -> next cycle instr_valid=0, count=0, illegal_err=0, req_ready=1.
- With INSTR_ENCODER_NOP_INSERT_EN defined, BEQ rs=1 rt=2 imm=0xFFFF -> outputs 0x1022FFFF then 0x00000000. With 3 entries occupied, the BEQ is held off until 2 slots are free.
